// File: rtl/ifu_pkg.sv
// Shared IFU types and parcel-decode helpers, used by the aligner and the decompressor.
package ifu_pkg;

    localparam int PARCEL_W = 16;
    localparam int INSTR_W  = 32;

    typedef logic [PARCEL_W-1:0] parcel_t;

    function automatic logic instr_is_compressed(parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

    // Encodings with bits [4:0] all set announce instructions longer than 32 bits.
    function automatic logic instr_is_illegal_len(parcel_t p);
        return p[4:0] == 5'b11111;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Fetch-word to instruction aligner: buffers 16-bit parcels and emits one aligned instruction per cycle.
// Define FETCH_ALIGN_ILLEGAL_EN to add illegal_out (zero parcel / over-long encoding detection).
module fetch_align
    import ifu_pkg::*;
#(
    parameter int          BUF_HALVES = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  fetch_data_in,
    input  logic                fetch_valid_in,
    output logic                fetch_ready_out,
    input  logic                flush_in,
    input  logic [31:0]         flush_pc_in,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [31:0]         instr_pc_out,
    output logic                instr_compressed_out,
    output logic                instr_valid_out,
`ifdef FETCH_ALIGN_ILLEGAL_EN
    output logic                illegal_out,
`endif
    input  logic                instr_ready_in
);

    localparam int BW = BUF_HALVES * PARCEL_W;
    localparam int CW = $clog2(BUF_HALVES + 1);
    localparam int SW = $clog2(BW + 1);

    logic [BW-1:0]  buf_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    head_pc_q;
    logic           skip_q;

    logic [BW-1:0]  buf_d;
    logic [CW-1:0]  count_d;
    logic [CW-1:0]  base;
    logic [31:0]    head_pc_d;
    logic [BW-1:0]  app_word;
    logic [BW-1:0]  keep_mask;
    logic [SW-1:0]  sh_cons;
    logic [SW-1:0]  sh_base;
    logic [1:0]     consumed;
    logic [1:0]     appended;
    parcel_t        p0;
    parcel_t        p1;
    logic           head_short;
    logic           fire;
    logic           accept;
    logic           unused_flush_bit;

    assign p0 = buf_q[PARCEL_W-1:0];
    assign p1 = buf_q[2*PARCEL_W-1:PARCEL_W];
    assign unused_flush_bit = flush_pc_in[0];

    // Over-long encodings are emitted as a single parcel so the trap path never waits on data.
`ifdef FETCH_ALIGN_ILLEGAL_EN
    assign head_short = instr_is_compressed(p0) || instr_is_illegal_len(p0);
`else
    assign head_short = instr_is_compressed(p0);
`endif

    always_comb begin
        instr_valid_out      = (count_q != '0) && (head_short || (count_q >= CW'(2)));
        instr_compressed_out = instr_valid_out && head_short;
        instr_pc_out         = head_pc_q;
        instr_out            = '0;
        if (instr_valid_out) begin
            instr_out = head_short ? {16'h0000, p0} : {p1, p0};
        end
    end

`ifdef FETCH_ALIGN_ILLEGAL_EN
    assign illegal_out = instr_valid_out && ((p0 == '0) || instr_is_illegal_len(p0));
`endif

    assign fetch_ready_out = !flush_in && (count_q <= CW'(BUF_HALVES - 2));
    assign fire            = instr_valid_out && instr_ready_in;
    assign accept          = fetch_valid_in && fetch_ready_out;

    // Shift out consumed parcels, then drop the new ones in just above what remains.
    always_comb begin
        consumed  = fire ? (head_short ? 2'd1 : 2'd2) : 2'd0;
        appended  = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        app_word  = skip_q ? BW'(fetch_data_in[31:16]) : BW'(fetch_data_in);
        base      = count_q - CW'(consumed);
        sh_cons   = SW'(consumed) * SW'(PARCEL_W);
        sh_base   = SW'(base) * SW'(PARCEL_W);
        keep_mask = (BW'(1) << sh_base) - BW'(1);
        buf_d     = (buf_q >> sh_cons) & keep_mask;
        if (accept) begin
            buf_d = buf_d | (app_word << sh_base);
        end
        count_d   = base + CW'(appended);
        head_pc_d = head_pc_q;
        if (fire) begin
            head_pc_d = head_pc_q + (head_short ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q     <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
            skip_q    <= 1'b0;
        end else if (flush_in) begin
            count_q   <= '0;
            head_pc_q <= {flush_pc_in[31:1], 1'b0};
            skip_q    <= flush_pc_in[1];
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            if (accept) begin
                skip_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: parcel-queue reference model plus directed literal checks.
module tb_fetch_align;
    import ifu_pkg::*;

    localparam int          BH  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] fetch_data_in;
    logic        fetch_valid_in;
    logic        fetch_ready_out;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_compressed_out;
    logic        instr_valid_out;
    logic        instr_ready_in;
`ifdef FETCH_ALIGN_ILLEGAL_EN
    logic        illegal_out;
`endif

    int checks = 0;
    int errors = 0;

    fetch_align #(.BUF_HALVES(BH), .RESET_PC(RPC)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .fetch_data_in        (fetch_data_in),
        .fetch_valid_in       (fetch_valid_in),
        .fetch_ready_out      (fetch_ready_out),
        .flush_in             (flush_in),
        .flush_pc_in          (flush_pc_in),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
        .instr_compressed_out (instr_compressed_out),
        .instr_valid_out      (instr_valid_out),
`ifdef FETCH_ALIGN_ILLEGAL_EN
        .illegal_out          (illegal_out),
`endif
        .instr_ready_in       (instr_ready_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of parcels with the PC of its head.
    logic [15:0] mq[$];
    logic [31:0] m_pc   = RPC;
    logic        m_skip = 1'b0;

    function automatic bit m_short(input logic [15:0] p);
`ifdef FETCH_ALIGN_ILLEGAL_EN
        return (p[1:0] != 2'b11) || (p[4:0] == 5'b11111);
`else
        return p[1:0] != 2'b11;
`endif
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        return m_short(mq[0]) || (mq.size() >= 2);
    endfunction

    function automatic logic [31:0] m_instr();
        if (m_short(mq[0])) return {16'h0000, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    function automatic bit m_fready();
        return !flush_in && ((BH - mq.size()) >= 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit fire;
        bit acc;
        if (!reset_n) begin
            mq.delete();
            m_pc   = RPC;
            m_skip = 1'b0;
        end else begin
            fire = m_valid() && instr_ready_in;
            acc  = fetch_valid_in && m_fready();
            if (flush_in) begin
                mq.delete();
                m_pc   = {flush_pc_in[31:1], 1'b0};
                m_skip = flush_pc_in[1];
            end else begin
                if (fire) begin
                    if (m_short(mq[0])) begin
                        void'(mq.pop_front());
                        m_pc = m_pc + 32'd2;
                    end else begin
                        void'(mq.pop_front());
                        void'(mq.pop_front());
                        m_pc = m_pc + 32'd4;
                    end
                end
                if (acc) begin
                    if (m_skip) begin
                        mq.push_back(fetch_data_in[31:16]);
                        m_skip = 1'b0;
                    end else begin
                        mq.push_back(fetch_data_in[15:0]);
                        mq.push_back(fetch_data_in[31:16]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fetch_ready", 32'(fetch_ready_out), 32'(m_fready()));
        chk("instr_valid", 32'(instr_valid_out), 32'(m_valid()));
        if (m_valid()) begin
            chk("instr", instr_out, m_instr());
            chk("instr_pc", instr_pc_out, m_pc);
            chk("compressed", 32'(instr_compressed_out), 32'(m_short(mq[0])));
        end
`ifdef FETCH_ALIGN_ILLEGAL_EN
        if (m_valid())
            chk("illegal", 32'(illegal_out), 32'((mq[0] == 16'h0000) || (mq[0][4:0] == 5'b11111)));
        else
            chk("illegal_idle", 32'(illegal_out), 32'd0);
`endif
    end

    task automatic cyc(input bit fv, input logic [31:0] fd, input bit fl,
                       input logic [31:0] fpc, input bit rdy);
        @(posedge clk);
        #1;
        fetch_valid_in = fv;
        fetch_data_in  = fd;
        flush_in       = fl;
        flush_pc_in    = fpc;
        instr_ready_in = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n        = 1'b0;
        fetch_valid_in = 1'b0;
        fetch_data_in  = '0;
        flush_in       = 1'b0;
        flush_pc_in    = '0;
        instr_ready_in = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic lit(input string nm, input logic [31:0] ei, input logic [31:0] epc, input bit ec);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(instr_valid_out), 32'd1);
        chk({nm, "_instr"}, instr_out, ei);
        chk({nm, "_pc"}, instr_pc_out, epc);
        chk({nm, "_c"}, 32'(instr_compressed_out), 32'(ec));
    endtask

    initial begin
        reset_n        = 1'b0;
        fetch_valid_in = 1'b0;
        fetch_data_in  = '0;
        flush_in       = 1'b0;
        flush_pc_in    = '0;
        instr_ready_in = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid_out), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", instr_pc_out, RPC);
        chk("rst_c", 32'(instr_compressed_out), 32'd0);
        chk("rst_fready", 32'(fetch_ready_out), 32'd1);
        do_reset();

        // aligned 32-bit stream
        cyc(1, 32'h0000_0013, 0, 0, 1);
        cyc(1, 32'h0010_0093, 0, 0, 1);
        lit("al0", 32'h0000_0013, 32'h0, 0);
        cyc(0, 32'h0, 0, 0, 1);
        lit("al1", 32'h0010_0093, 32'h4, 0);

        // compressed pair
        do_reset();
        cyc(1, 32'h4001_4501, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("cp0", 32'h0000_4501, 32'h0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("cp1", 32'h0000_4001, 32'h2, 1);

        // straddling 32-bit instruction
        do_reset();
        cyc(1, 32'h0013_4501, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("st0", 32'h0000_4501, 32'h0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        @(negedge clk);
        chk("st_stall", 32'(instr_valid_out), 32'd0);
        cyc(1, 32'h0000_0001, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("st1", 32'h0001_0013, 32'h2, 0);
        cyc(0, 32'h0, 0, 0, 0);
        lit("st2", 32'h0000_0000, 32'h6, 1);
`ifdef FETCH_ALIGN_ILLEGAL_EN
        chk("st2_illegal", 32'(illegal_out), 32'd1);
`endif

        // flush with a competing fetch word
        cyc(1, 32'hDEAD_BEEF, 1, 32'h0000_0102, 0);
        @(negedge clk);
        chk("fl_fready", 32'(fetch_ready_out), 32'd0);
        cyc(1, 32'h0001_4501, 0, 0, 1);
        @(negedge clk);
        chk("fl_valid0", 32'(instr_valid_out), 32'd0);
        cyc(0, 32'h0, 0, 0, 1);
        lit("fl0", 32'h0000_0001, 32'h102, 1);

        // backpressure
        do_reset();
        cyc(1, 32'h0093_0013, 0, 0, 0);
        cyc(1, 32'h4001_4501, 0, 0, 0);
        cyc(1, 32'h0010_0093, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            lit("bp_hold", 32'h0093_0013, 32'h0, 0);
            chk("bp_fready", 32'(fetch_ready_out), 32'd0);
            cyc(1, 32'h0010_0093, 0, 0, (i == 3));
        end
        lit("bp0", 32'h0093_0013, 32'h0, 0);
        cyc(1, 32'h0010_0093, 0, 0, 1);
        lit("bp1", 32'h0000_4501, 32'h4, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("bp2", 32'h0000_4001, 32'h6, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("bp3", 32'h0010_0093, 32'h8, 0);

        // asynchronous reset mid-straddle
        do_reset();
        cyc(1, 32'h0013_4501, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(instr_valid_out), 32'd0);
        chk("ar_instr", instr_out, 32'd0);
        chk("ar_pc", instr_pc_out, RPC);
        chk("ar_c", 32'(instr_compressed_out), 32'd0);
        chk("ar_fready", 32'(fetch_ready_out), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc(1, 32'h0000_0013, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        lit("ar0", 32'h0000_0013, RPC, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] fpc;
            logic [31:0] fd;
            fpc = $urandom;
            if ($urandom_range(0, 3) == 0) fpc = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            fd = $urandom;
            if ($urandom_range(0, 7) == 0) fd[4:0] = 5'b11111;
            if ($urandom_range(0, 7) == 0) fd[15:0] = 16'h0000;
            cyc($urandom_range(0, 9) < 7, fd, $urandom_range(0, 99) < 3, fpc,
                $urandom_range(0, 9) < 7);
        end
        cyc(0, 32'h0, 0, 0, 1);
        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
